// File: rtl/crb_xfer_pkg.sv
// Shared types and helpers for the CRB transfer sequencer.
package crb_xfer_pkg;

  localparam int unsigned DEFAULT_BUF_SIZE = 4096;
  localparam int unsigned TPM_HDR_LEN      = 10;

  typedef enum logic [2:0] {
    StIdle,
    StCmdRd,
    StCmdDrain,
    StCmdDone,
    StRspDly,
    StRspRd,
    StRspDrain,
    StRspDone
  } xfer_state_e;

  // Header sizes are 32 bits but a transfer can never exceed the buffer depth.
  function automatic int unsigned clamp_len(logic [31:0] size, int unsigned buf_size);
    return (size > buf_size) ? buf_size : size;
  endfunction

endpackage

// File: rtl/crb_xfer_ctrl_if.sv
// CRB-side FIFO handshake, execution-engine handshake and CRB RAM port.
interface crb_xfer_ctrl_if #(
  parameter int unsigned BUF_SIZE = 4096
);

  localparam int unsigned AddrW = $clog2(BUF_SIZE);

  logic              cmd_send;
  logic [31:0]       cmd_size;
  logic [7:0]        cmd_byte;
  logic [AddrW-1:0]  cmd_in_addr;
  logic              cmd_done;
  logic              exec_done;
  logic [31:0]       exec_rsp_size;
  logic [31:0]       rsp_size;
  logic [AddrW-1:0]  rsp_in_addr;
  logic              rsp_send;
  logic [7:0]        rsp_byte;
  logic              rsp_done;
  logic [AddrW-1:0]  crb_addr;
  logic              crb_wren_n;
  logic [7:0]        crb_wr_byte;
  logic [7:0]        crb_rd_byte;
  logic              abort;

  modport master (
    input  cmd_send, cmd_size, cmd_byte, exec_done, exec_rsp_size, crb_rd_byte, abort,
    output cmd_in_addr, cmd_done, rsp_size, rsp_in_addr, rsp_send, rsp_byte, rsp_done,
    output crb_addr, crb_wren_n, crb_wr_byte
  );

  modport slave (
    output cmd_send, cmd_size, cmd_byte, exec_done, exec_rsp_size, crb_rd_byte, abort,
    input  cmd_in_addr, cmd_done, rsp_size, rsp_in_addr, rsp_send, rsp_byte, rsp_done,
    input  crb_addr, crb_wren_n, crb_wr_byte
  );

endinterface

// File: rtl/xfer_pipe.sv
// One-stage valid/address delay that lines up a write with 1-cycle-latency read data.
module xfer_pipe #(
  parameter int unsigned AddrW = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [AddrW-1:0] in_addr,
  output logic             valid,
  output logic [AddrW-1:0] addr
);

  logic             valid_q;
  logic [AddrW-1:0] addr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= in_valid & ~clr;
      if (in_valid) begin
        addr_q <= in_addr;
      end
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;

endmodule

// File: rtl/crb_xfer_ctrl.sv
// Moves command bytes FIFO -> CRB RAM and response bytes CRB RAM -> FIFO.
// Optional CRB_XFER_CHKSUM_EN adds xfer_chk, the XOR of all bytes written in a transfer.
module crb_xfer_ctrl
  import crb_xfer_pkg::*;
#(
  parameter int unsigned BUF_SIZE      = DEFAULT_BUF_SIZE,
  parameter int unsigned RSP_START_DLY = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  crb_xfer_ctrl_if.master bus
`ifdef CRB_XFER_CHKSUM_EN
  ,
  output logic [7:0]      xfer_chk
`endif
);

  localparam int unsigned AddrW = $clog2(BUF_SIZE);
  // One extra bit so an index reaching BUF_SIZE does not wrap to zero.
  localparam int unsigned IdxW  = AddrW + 1;
  localparam int unsigned DlyW  = (RSP_START_DLY > 1) ? $clog2(RSP_START_DLY) : 1;

  xfer_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] len_q, len_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [31:0]     rsp_size_q, rsp_size_d;

  logic [IdxW-1:0]  cmd_len, rsp_len;
  logic             pipe_in_valid;
  logic             pipe_valid;
  logic [AddrW-1:0] pipe_addr;
  logic             rsp_phase;
  logic             cmd_wr, rsp_wr;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      len_q      <= '0;
      dly_q      <= '0;
      rsp_size_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      dly_q      <= dly_d;
      rsp_size_q <= rsp_size_d;
    end
  end

  always_comb begin
    cmd_len    = IdxW'(clamp_len(bus.cmd_size, BUF_SIZE));
    rsp_len    = IdxW'(clamp_len(bus.exec_rsp_size, BUF_SIZE));
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    dly_d      = dly_q;
    rsp_size_d = rsp_size_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Command wins a same-cycle collision; the response start is dropped.
          if (bus.cmd_send) begin
            len_d   = cmd_len;
            idx_d   = '0;
            state_d = (cmd_len == '0) ? StCmdDone : StCmdRd;
          end else if (bus.exec_done) begin
            rsp_size_d = bus.exec_rsp_size;
            len_d      = rsp_len;
            idx_d      = '0;
            dly_d      = '0;
            state_d    = (rsp_len == '0) ? StRspDone : StRspDly;
          end
        end
        StCmdRd: begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == len_q - IdxW'(1)) begin
            state_d = StCmdDrain;
          end
        end
        StCmdDrain: state_d = StCmdDone;
        StCmdDone:  state_d = StIdle;
        StRspDly: begin
          dly_d = dly_q + DlyW'(1);
          if (int'(dly_q) + 1 >= int'(RSP_START_DLY)) begin
            state_d = StRspRd;
          end
        end
        StRspRd: begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == len_q - IdxW'(1)) begin
            state_d = StRspDrain;
          end
        end
        StRspDrain: state_d = StRspDone;
        StRspDone:  state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pipe_in_valid = !bus.abort && ((state_q == StCmdRd) || (state_q == StRspRd));
  end

  xfer_pipe #(
    .AddrW (AddrW)
  ) u_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (bus.abort),
    .in_valid (pipe_in_valid),
    .in_addr  (idx_q[AddrW-1:0]),
    .valid    (pipe_valid),
    .addr     (pipe_addr)
  );

  // The delayed write belongs to whichever direction the state machine is still in.
  always_comb begin
    rsp_phase = (state_q == StRspRd) || (state_q == StRspDrain);
    cmd_wr    = pipe_valid && !rsp_phase;
    rsp_wr    = pipe_valid && rsp_phase;
  end

  always_comb begin
    bus.cmd_in_addr = idx_q[AddrW-1:0];
    bus.cmd_done    = (state_q == StCmdDone);
    bus.rsp_done    = (state_q == StRspDone);
    bus.rsp_size    = rsp_size_q;
    bus.crb_addr    = (state_q == StRspRd) ? idx_q[AddrW-1:0] : pipe_addr;
    bus.crb_wren_n  = ~cmd_wr;
    bus.crb_wr_byte = cmd_wr ? bus.cmd_byte : 8'hFF;
    bus.rsp_in_addr = pipe_addr;
    bus.rsp_send    = ~rsp_wr;
    bus.rsp_byte    = rsp_wr ? bus.crb_rd_byte : 8'hFF;
  end

`ifdef CRB_XFER_CHKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       xfer_start;

  always_comb begin
    xfer_start = (state_q == StIdle) && !bus.abort && (bus.cmd_send || bus.exec_done);
    chk_d      = chk_q;
    if (xfer_start) begin
      chk_d = '0;
    end else if (cmd_wr) begin
      chk_d = chk_q ^ bus.cmd_byte;
    end else if (rsp_wr) begin
      chk_d = chk_q ^ bus.crb_rd_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign xfer_chk = chk_q;
`endif

endmodule

// File: tb/tb_crb_xfer_ctrl.sv
// Scoreboard bench for crb_xfer_ctrl: expected events are queued at stimulus time.
module tb_crb_xfer_ctrl;

  localparam int unsigned BufSize = 4096;
  localparam int unsigned RspDly  = 2;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;

  ev_t q_crb[$];
  ev_t q_fifo[$];
  ev_t q_rsz[$];
  int  q_cdone[$];
  int  q_rdone[$];

  logic [7:0]  fifo_src  [BufSize];
  logic [7:0]  crb_mem   [BufSize];
  logic [7:0]  model_crb [BufSize];
  logic [31:0] last_rsp_size = '0;

  crb_xfer_ctrl_if #(.BUF_SIZE(BufSize)) bus ();

`ifdef CRB_XFER_CHKSUM_EN
  logic [7:0] xfer_chk;
`endif

  crb_xfer_ctrl #(
    .BUF_SIZE      (BufSize),
    .RSP_START_DLY (RspDly)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CRB_XFER_CHKSUM_EN
    ,
    .xfer_chk (xfer_chk)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // FIFO read port and CRB RAM, both with 1-cycle read latency.
  always @(posedge clock) begin
    bus.cmd_byte <= fifo_src[bus.cmd_in_addr];
    if (!bus.crb_wren_n) crb_mem[bus.crb_addr] <= bus.crb_wr_byte;
    bus.crb_rd_byte <= crb_mem[bus.crb_addr];
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ev(string name, ev_t g, ev_t e);
    checks++;
    if (g.cyc != e.cyc || g.addr != e.addr || g.data != e.data) begin
      failures++;
      $display("FAIL %s: got cyc=%0d addr=0x%0h data=0x%0h required cyc=%0d addr=0x%0h data=0x%0h",
               name, g.cyc, g.addr, g.data, e.cyc, e.addr, e.data);
    end
  endtask

  task automatic flag(string name, int got_cyc, int exp_cyc);
    checks++;
    failures++;
    $display("FAIL %s: got event at cyc=%0d required cyc=%0d", name, got_cyc, exp_cyc);
  endtask

  task automatic monitor();
    ev_t e, g;
    int  c;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (!bus.crb_wren_n) begin
          g = '{cyc, int'(bus.crb_addr), int'(bus.crb_wr_byte)};
          if (q_crb.size() == 0) flag("crb_wr_unexpected", cyc, -1);
          else begin e = q_crb.pop_front(); check_ev("crb_wr", g, e); end
        end else if (q_crb.size() != 0 && q_crb[0].cyc < cyc) begin
          e = q_crb.pop_front();
          flag("crb_wr_missing", -1, e.cyc);
        end
        if (!bus.rsp_send) begin
          g = '{cyc, int'(bus.rsp_in_addr), int'(bus.rsp_byte)};
          if (q_fifo.size() == 0) flag("fifo_wr_unexpected", cyc, -1);
          else begin e = q_fifo.pop_front(); check_ev("fifo_wr", g, e); end
        end else if (q_fifo.size() != 0 && q_fifo[0].cyc < cyc) begin
          e = q_fifo.pop_front();
          flag("fifo_wr_missing", -1, e.cyc);
        end
        if (bus.cmd_done) begin
          if (q_cdone.size() == 0) flag("cmd_done_unexpected", cyc, -1);
          else begin c = q_cdone.pop_front(); check("cmd_done_cyc", 64'(cyc), 64'(c)); end
        end else if (q_cdone.size() != 0 && q_cdone[0] < cyc) begin
          c = q_cdone.pop_front();
          flag("cmd_done_missing", -1, c);
        end
        if (bus.rsp_done) begin
          if (q_rdone.size() == 0) flag("rsp_done_unexpected", cyc, -1);
          else begin c = q_rdone.pop_front(); check("rsp_done_cyc", 64'(cyc), 64'(c)); end
        end else if (q_rdone.size() != 0 && q_rdone[0] < cyc) begin
          c = q_rdone.pop_front();
          flag("rsp_done_missing", -1, c);
        end
        if (q_rsz.size() != 0 && q_rsz[0].cyc == cyc) begin
          e = q_rsz.pop_front();
          check("rsp_size", 64'(bus.rsp_size), 64'(unsigned'(e.data)));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Caller is already 1 time unit past a rising edge; the pulse occupies the current cycle.
  task automatic do_cmd(logic [31:0] size, bit also_exec);
    int n, t;
    n = (size > BufSize) ? int'(BufSize) : int'(size);
    t = cyc;
    bus.cmd_send      = 1'b1;
    bus.cmd_size      = size;
    bus.exec_done     = also_exec;
    bus.exec_rsp_size = 32'd77;
    for (int i = 0; i < n; i++) begin
      q_crb.push_back('{t + 2 + i, i, int'(fifo_src[i])});
      model_crb[i] = fifo_src[i];
    end
    q_cdone.push_back((n == 0) ? t + 1 : t + n + 2);
    if (also_exec) q_rsz.push_back('{t + 2, 0, int'(last_rsp_size)});
    step();
    bus.cmd_send  = 1'b0;
    bus.exec_done = 1'b0;
  endtask

  task automatic do_rsp(logic [31:0] size);
    int n, e;
    n = (size > BufSize) ? int'(BufSize) : int'(size);
    e = cyc;
    bus.exec_done     = 1'b1;
    bus.exec_rsp_size = size;
    q_rsz.push_back('{e + 1, 0, int'(size)});
    last_rsp_size = size;
    for (int i = 0; i < n; i++) begin
      q_fifo.push_back('{e + 2 + int'(RspDly) + i, i, int'(model_crb[i])});
    end
    q_rdone.push_back((n == 0) ? e + 1 : e + 2 + int'(RspDly) + n);
    step();
    bus.exec_done = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((q_crb.size() + q_fifo.size() + q_cdone.size() + q_rdone.size() + q_rsz.size()) != 0
           && n < budget) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending events after %0d cycles required 0",
               q_crb.size() + q_fifo.size() + q_cdone.size() + q_rdone.size() + q_rsz.size(), n);
      q_crb.delete(); q_fifo.delete(); q_cdone.delete(); q_rdone.delete(); q_rsz.delete();
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    int n, m, t;
    bus.cmd_send      = 1'b0;
    bus.cmd_size      = '0;
    bus.exec_done     = 1'b0;
    bus.exec_rsp_size = '0;
    bus.abort         = 1'b0;
    for (int i = 0; i < int'(BufSize); i++) begin
      fifo_src[i]  = 8'h00;
      model_crb[i] = 8'h00;
    end

    repeat (3) step();
    check("rst_crb_wren_n", 64'(bus.crb_wren_n), 64'd1);
    check("rst_rsp_send", 64'(bus.rsp_send), 64'd1);
    check("rst_cmd_done", 64'(bus.cmd_done), 64'd0);
    check("rst_rsp_done", 64'(bus.rsp_done), 64'd0);
    check("rst_rsp_size", 64'(bus.rsp_size), 64'd0);
    check("rst_crb_wr_byte", 64'(bus.crb_wr_byte), 64'hFF);
    check("rst_rsp_byte", 64'(bus.rsp_byte), 64'hFF);
    check("rst_crb_addr", 64'(bus.crb_addr), 64'd0);
    check("rst_cmd_in_addr", 64'(bus.cmd_in_addr), 64'd0);
    check("rst_rsp_in_addr", 64'(bus.rsp_in_addr), 64'd0);
    reset_n = 1'b1;
    fork
      monitor();
    join_none
    step();

    // 12-byte command of 0x00..0x0B.
    for (int i = 0; i < 12; i++) fifo_src[i] = 8'(i);
    do_cmd(32'd12, 1'b0);
    wait_idle(200);

    // Load CRB with 0xA0..0xA9, then a 10-byte response.
    for (int i = 0; i < 10; i++) fifo_src[i] = 8'hA0 + 8'(i);
    do_cmd(32'd10, 1'b0);
    wait_idle(200);
    do_rsp(32'd10);
    wait_idle(200);

    // Empty command.
    do_cmd(32'd0, 1'b0);
    wait_idle(50);

    // Abort at T+5 of a 20-byte command, then restart in the very next cycle.
    for (int i = 0; i < 20; i++) fifo_src[i] = 8'($urandom);
    t = cyc;
    bus.cmd_send = 1'b1;
    bus.cmd_size = 32'd20;
    for (int i = 0; i < 4; i++) begin
      q_crb.push_back('{t + 2 + i, i, int'(fifo_src[i])});
      model_crb[i] = fifo_src[i];
    end
    step();
    bus.cmd_send = 1'b0;
    repeat (4) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    do_cmd(32'd5, 1'b0);
    wait_idle(100);

    // Simultaneous starts: the command runs, the response size is untouched.
    do_cmd(32'd6, 1'b1);
    wait_idle(100);
    check("rsp_size_after_collision", 64'(bus.rsp_size), 64'(last_rsp_size));

    // Start pulses outside IDLE are ignored.
    for (int i = 0; i < 15; i++) fifo_src[i] = 8'($urandom);
    do_cmd(32'd15, 1'b0);
    repeat (3) step();
    bus.exec_done     = 1'b1;
    bus.exec_rsp_size = 32'd99;
    step();
    bus.exec_done = 1'b0;
    wait_idle(100);
    check("rsp_size_after_stray", 64'(bus.rsp_size), 64'(last_rsp_size));
    do_rsp(32'd8);
    step();
    step();
    bus.cmd_send = 1'b1;
    bus.cmd_size = 32'd3;
    step();
    bus.cmd_send = 1'b0;
    wait_idle(100);

    // Randomised command/response pairs.
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(0, 40));
      m = int'($urandom_range(0, n));
      for (int i = 0; i < n; i++) fifo_src[i] = 8'($urandom);
      do_cmd(32'(n), 1'b0);
      wait_idle(200);
      do_rsp(32'(m));
      wait_idle(200);
    end

    // Oversized sizes clamp to the full buffer without wrapping.
    for (int i = 0; i < int'(BufSize); i++) fifo_src[i] = 8'($urandom);
    do_cmd(32'h0001_0000, 1'b0);
    wait_idle(6000);
    do_rsp(32'd5000);
    wait_idle(6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
